dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the pipeline's MEM-stage data port (MemRead/MemWrite/addr/wdata).
//  Owns the data RAM and models a multi-cycle memory.
//  Holds the pipeline via 'stall' until each access completes.
//  Lets the pipeline run against realistic memory latency instead of a zero-wait-state mem32.
// PARAMETERS
//  DEPTH    256  words of storage; power of two
//  LATENCY  3    stall cycles per access; legal range 1..15
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   synchronous, active-high
//  req_read   in   1   MEM_MemRead from pipeline
//  req_write  in   1   MEM_MemWrite from pipeline
//  req_addr   in   32  byte address (MEM_ALUOut)
//  req_wdata  in   32  store data (MEM_rd2)
//  stall      out  1   freeze IF/ID/EX/MEM; combinational from state and request
//  rdata      out  32  load data; registered
//  rvalid     out  1   one-cycle pulse; rdata valid for the completing load
//  err        out  1   one-cycle pulse on misaligned or conflicting request
// BEHAVIOUR
//  Interface
//   - Reset: clk and reset are as listed under PORTS.
//   - Reset drives state=IDLE, stall=0, rvalid=0, err=0, rdata=0, count=0.
//   - RAM contents are not reset.
//  Addressing
//   - Word index = req_addr[log2(DEPTH)+1:2]; upper address bits are ignored (wraps modulo DEPTH).
//   - Misaligned access (req_addr[1:0]!=0 with a request):
//     - no access is performed, no stall;
//     - err=1 for that one cycle;
//     - FSM stays IDLE.
//   - req_read and req_write both high:
//     - treated as a write;
//     - err=1 in the accept cycle;
//     - the access otherwise proceeds normally.
//  FSM states
//   - IDLE:
//     - stall = req_read|req_write (aligned).
//     - On an aligned request at cycle T: latch addr/wdata/kind, count=LATENCY-1, go to BUSY.
//   - BUSY:
//     - stall=1.
//     - count decrements each cycle.
//     - At count==0, go to DONE.
//   - DONE:
//     - stall=0, so the pipeline advances at the end of this cycle.
//     - Load: rdata=mem[idx] was loaded at the edge entering DONE; rvalid=1.
//     - Store: mem[idx]<=wdata at the edge leaving DONE.
//     - Next state is IDLE.
//   - The edge after DONE is an IDLE cycle with a new request evaluated combinationally, so back-to-back accesses are supported.
//  Timing
//   - stall is high in cycles T..T+LATENCY-1 (exactly LATENCY cycles).
//   - Completion is at T+LATENCY.
//   - A load issued the cycle after a store completes returns the new data.
//  Request stability
//   - The pipeline holds req_* stable while stall=1.
//   - The responder uses only the latched copy after T; later changes are ignored.
//  Reset mid-operation
//   - Any state goes to IDLE.
//   - A pending store is discarded, so RAM is unchanged.
//   - A pending load produces no rvalid.
//  Outputs
//   - rdata holds its last value when rvalid=0.
// STRUCTURE
//  - Package mips_mem_pkg:
//    - state encoding localparams S_IDLE/S_BUSY/S_DONE;
//    - WORD_W=32;
//    - latency counter width CNT_W=4.
//  - Sub-module dmem_array:
//    - DEPTH x 32;
//    - one synchronous write port, one synchronous read port;
//    - read-before-write is not required, because the FSM never reads and writes in the same cycle.
//  - dmem_responder contains the FSM, request latch, counter and err/rvalid logic.
// TESTING
//  - Load, LATENCY=3:
//    - preload mem[4]=0xDEADBEEF;
//    - req_read=1, addr=0x10 at T;
//    - stall=1 in T..T+2; at T+3 stall=0, rvalid=1, rdata=0xDEADBEEF.
//  - Store then load:
//    - write 0x12345678 to addr=0x20 (stall 3 cycles, completes at T+3);
//    - read 0x20 at T+4;
//    - rvalid at T+7 with rdata=0x12345678.
//  - Misaligned:
//    - req_read=1, addr=0x13;
//    - err=1 the same cycle, stall=0, no rvalid, RAM unchanged.
//  - Conflict:
//    - req_read=req_write=1, addr=0x8, wdata=0xA5A5A5A5;
//    - err pulse at T;
//    - a subsequent read of 0x8 returns 0xA5A5A5A5.
//  - Reset mid-store:
//    - write 0xFFFFFFFF to 0x30 (mem[12] was 0x1);
//    - assert reset at T+1;
//    - stall=0 after reset; a read of 0x30 returns 0x1.
//  - Wrap and back-to-back, DEPTH=256:
//    - write 0x77 at addr=0x400, then read addr=0x0 the cycle after DONE;
//    - rdata=0x77, with no idle gap required between accesses.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and widths for the MEM-stage data-port responder.
package mips_mem_pkg;
   localparam int WORD_W = 32;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/dmem_responder_if.sv
// Pipeline MEM-stage data port: request from the pipeline, stall/load data back.
interface dmem_responder_if;
   import mips_mem_pkg::*;

   logic              req_read;
   logic              req_write;
   logic [WORD_W-1:0] req_addr;
   logic [WORD_W-1:0] req_wdata;
   logic              stall;
   logic [WORD_W-1:0] rdata;
   logic              rvalid;
   logic              err;

   modport master (
      output req_read, req_write, req_addr, req_wdata,
      input  stall, rdata, rvalid, err
   );

   modport slave (
      input  req_read, req_write, req_addr, req_wdata,
      output stall, rdata, rvalid, err
   );
endinterface

// File: rtl/dmem_array.sv
// Data RAM: one synchronous write port and one registered read port.
module dmem_array
   import mips_mem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [WORD_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [AW-1:0]     i_raddr,
   output logic [WORD_W-1:0] o_rdata
);
   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [WORD_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Only the read register is reset; storage keeps its contents.
   always_ff @(posedge clk) begin
      if (reset)     r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory behind the MEM stage; stalls the pipeline until each access completes.
// state  | meaning
// S_IDLE | waiting for a request; an aligned request stalls and is latched
// S_BUSY | latency countdown, stall held
// S_DONE | access completes: load data valid, store committed at the exit edge
module dmem_responder
   import mips_mem_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 3
) (
   input  logic              clk,
   input  logic              reset,
   dmem_responder_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_count, w_count_nxt;
   logic [AW-1:0]     r_idx;
   logic [WORD_W-1:0] r_wdata;
   logic              r_write;

   logic              w_req, w_aligned, w_accept;
   logic              w_stall, w_err, w_rvalid, w_re, w_we;
   logic [AW-1:0]     w_idx, w_raddr;
   logic              w_unused_addr;

   assign w_req     = bus.req_read | bus.req_write;
   assign w_aligned = (bus.req_addr[1:0] == 2'b00);
   assign w_accept  = (r_state == S_IDLE) && w_req && w_aligned && !reset;
   assign w_idx     = bus.req_addr[AW+1:2];
   assign w_unused_addr = ^bus.req_addr[WORD_W-1:AW+2];

   // With LATENCY==1 the load is read straight from the live address on accept.
   assign w_raddr = (r_state == S_IDLE) ? w_idx : r_idx;
   assign w_we    = (r_state == S_DONE) && r_write && !reset;

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_stall     = 1'b0;
      w_err       = 1'b0;
      w_rvalid    = 1'b0;
      w_re        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req && !reset) begin
               if (!w_aligned) begin
                  w_err = 1'b1;
               end else begin
                  w_stall     = 1'b1;
                  w_err       = bus.req_read & bus.req_write;
                  w_count_nxt = CNT_W'(LATENCY - 1);
                  if (LATENCY == 1) begin
                     w_state_nxt = S_DONE;
                     w_re        = !bus.req_write;
                  end else begin
                     w_state_nxt = S_BUSY;
                  end
               end
            end
         end
         S_BUSY: begin
            w_stall     = 1'b1;
            w_count_nxt = r_count - CNT_W'(1);
            if (r_count == CNT_W'(1)) begin
               w_state_nxt = S_DONE;
               w_re        = !r_write;
            end
         end
         S_DONE: begin
            w_rvalid    = !r_write;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_idx   <= w_idx;
         r_wdata <= bus.req_wdata;
         r_write <= bus.req_write;
      end
   end

   dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_we),
      .i_waddr (r_idx),
      .i_wdata (r_wdata),
      .i_re    (w_re),
      .i_raddr (w_raddr),
      .o_rdata (bus.rdata)
   );

   assign bus.stall  = w_stall;
   assign bus.err    = w_err;
   assign bus.rvalid = w_rvalid;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios with literal expectations plus random traffic
// checked every cycle against a cycle-count/array model of the memory.
module tb_dmem_responder;
   localparam int DEPTH = 256;
   localparam int LAT   = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dmem_responder_if bus ();

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: memory array plus "completes at cycle N" bookkeeping.
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_rdata;
   bit          m_busy;
   int          m_done_cyc;
   bit          m_write;
   int          m_idx;
   logic [31:0] m_wdata;
   int          cyc = 0;

   always @(negedge clk) begin
      bit   e_stall, e_err, e_rv, rq, al;
      cyc++;
      if (reset) begin
         m_busy  = 0;
         m_rdata = 32'h0;
      end else begin
         e_stall = 0; e_err = 0; e_rv = 0;
         if (m_busy) begin
            if (cyc < m_done_cyc) begin
               e_stall = 1;
            end else begin
               if (!m_write) begin
                  e_rv    = 1;
                  m_rdata = m_mem[m_idx];
               end
            end
         end else begin
            rq = bus.req_read | bus.req_write;
            al = (bus.req_addr % 4) == 0;
            if (rq && !al) e_err = 1;
            if (rq && al) begin
               e_stall    = 1;
               e_err      = bus.req_read & bus.req_write;
               m_busy     = 1;
               m_done_cyc = cyc + LAT;
               m_write    = bus.req_write;
               m_idx      = int'((bus.req_addr / 4) % DEPTH);
               m_wdata    = bus.req_wdata;
            end
         end
         chk("stall",  {31'b0, bus.stall},  {31'b0, e_stall});
         chk("err",    {31'b0, bus.err},    {31'b0, e_err});
         chk("rvalid", {31'b0, bus.rvalid}, {31'b0, e_rv});
         chk("rdata",  bus.rdata, m_rdata);
         if (m_busy && cyc == m_done_cyc) begin
            if (m_write) m_mem[m_idx] = m_wdata;
            m_busy = 0;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 of the cycle after completion with the request dropped,
   // so a following call issues back-to-back.
   task automatic xact(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       output int n_stall, output bit got_rv, output logic [31:0] got_rd,
                       output bit got_err);
      bit done;
      bus.req_read  = rd;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      n_stall = 0; got_rv = 0; got_rd = '0; got_err = 0; done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (bus.err) got_err = 1;
         if (bus.stall) n_stall++;
         else begin
            got_rv = bus.rvalid;
            got_rd = bus.rdata;
            done   = 1;
         end
      end
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL timeout: stall never dropped for addr %h", addr);
      end
      @(posedge clk); #1;
      bus.req_read  = 0;
      bus.req_write = 0;
   endtask

   int          ns;
   bit          rv, er;
   logic [31:0] rd;

   initial begin
      bus.req_read = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_wdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("reset_stall",  {31'b0, bus.stall},  32'h0);
      chk("reset_rvalid", {31'b0, bus.rvalid}, 32'h0);
      chk("reset_err",    {31'b0, bus.err},    32'h0);
      chk("reset_rdata",  bus.rdata, 32'h0);
      @(posedge clk); #1;

      // Fill every word so the model knows all contents; alternate upper address bits.
      for (int i = 0; i < DEPTH; i++)
         xact(0, 1, (32'(i) << 2) | ((i % 2) ? 32'h0000_1000 : 32'h0), 32'(i) * 32'h0101_0101 ^ 32'h5A00_00A5,
              ns, rv, rd, er);
      xact(0, 1, 32'h10, 32'hDEAD_BEEF, ns, rv, rd, er);
      xact(0, 1, 32'h30, 32'h0000_0001, ns, rv, rd, er);

      xact(1, 0, 32'h10, 32'h0, ns, rv, rd, er);
      chk("load_stall_cycles", 32'(ns), 32'd3);
      chk("load_rvalid", {31'b0, rv}, 32'h1);
      chk("load_rdata", rd, 32'hDEAD_BEEF);

      xact(0, 1, 32'h20, 32'h1234_5678, ns, rv, rd, er);
      chk("store_stall_cycles", 32'(ns), 32'd3);
      chk("store_no_rvalid", {31'b0, rv}, 32'h0);
      xact(1, 0, 32'h20, 32'h0, ns, rv, rd, er);
      chk("store_load_rdata", rd, 32'h1234_5678);

      xact(1, 0, 32'h13, 32'h0, ns, rv, rd, er);
      chk("misalign_err", {31'b0, er}, 32'h1);
      chk("misalign_stall", 32'(ns), 32'd0);
      chk("misalign_rvalid", {31'b0, rv}, 32'h0);
      xact(1, 0, 32'h10, 32'h0, ns, rv, rd, er);
      chk("misalign_ram_intact", rd, 32'hDEAD_BEEF);

      xact(1, 1, 32'h8, 32'hA5A5_A5A5, ns, rv, rd, er);
      chk("conflict_err", {31'b0, er}, 32'h1);
      chk("conflict_no_rvalid", {31'b0, rv}, 32'h0);
      xact(1, 0, 32'h8, 32'h0, ns, rv, rd, er);
      chk("conflict_readback", rd, 32'hA5A5_A5A5);

      bus.req_write = 1; bus.req_addr = 32'h30; bus.req_wdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      reset = 1; bus.req_write = 0;
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      chk("reset_mid_stall", {31'b0, bus.stall}, 32'h0);
      @(posedge clk); #1;
      xact(1, 0, 32'h30, 32'h0, ns, rv, rd, er);
      chk("reset_mid_store_discarded", rd, 32'h0000_0001);

      xact(0, 1, 32'h400, 32'h77, ns, rv, rd, er);
      xact(1, 0, 32'h0, 32'h0, ns, rv, rd, er);
      chk("wrap_b2b_stall", 32'(ns), 32'd3);
      chk("wrap_b2b_rdata", rd, 32'h77);

      // Random traffic, changed every cycle (changes during a stall must be ignored).
      for (int c = 0; c < 3000; c++) begin
         int sel;
         logic [31:0] a;
         sel = int'($urandom_range(0, 99));
         a   = ($urandom() & 32'hFFFF_FC00) | (32'($urandom_range(0, DEPTH - 1)) << 2);
         if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
         bus.req_addr  = a;
         bus.req_wdata = $urandom();
         bus.req_read  = (sel < 40) || (sel >= 85);
         bus.req_write = (sel >= 40 && sel < 75) || (sel >= 85 && sel < 92);
         reset = ($urandom_range(0, 199) == 0);
         @(posedge clk); #1;
      end
      reset = 0; bus.req_read = 0; bus.req_write = 0;
      repeat (LAT + 3) @(posedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
